// File: rtl/one_bit_one_to_four_tdm_demux.sv
// ---------------------------------------------------------------------------
// one_bit_one_to_four_tdm_demux
//
// Receive side of a 1-bit 4:1 time-division serializer. One serial bit is
// taken per enabled cycle. A sync marker identifies slot 0. The block tracks
// the slot index, reassembles channels a/b/c/d into registered parallel
// outputs, and reports framing errors.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   en           slot strobe; din/sync are sampled only when en=1
//   din          serial data bit for the current slot
//   sync         marks din as slot 0 (channel a)
//   a, b, c, d   registered channels for slots 0..3
//   frame_valid  one-cycle pulse: a..d were just updated with a full frame
//   locked       1 while in state LOCKED
//   sync_err     one-cycle pulse: sync seen at a nonzero slot while LOCKED
//   s1, s0       current expected slot index (s1 is MSB)
//   parity_err   one-cycle pulse: parity slot mismatch (DEMUX_PARITY_EN only)
//
// Optional feature macro: DEMUX_PARITY_EN
//   Adds a fifth slot carrying even parity over a..d. The outputs update only
//   when the parity bit matches; otherwise parity_err pulses and a..d hold.
//
// States:
//   HUNT   | waiting for a sync marker; serial bits are ignored
//   LOCKED | slot counter running; flywheels over up to SYNC_MISS_MAX-1
//          | missing syncs at slot 0
// ---------------------------------------------------------------------------
module one_bit_one_to_four_tdm_demux #(
  parameter int SYNC_MISS_MAX = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic din,
  input  logic sync,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic frame_valid,
  output logic locked,
  output logic sync_err,
  output logic s0,
  output logic s1
`ifdef DEMUX_PARITY_EN
  ,
  output logic parity_err
`endif
);

`ifdef DEMUX_PARITY_EN
  localparam int CNT_W  = 3;
  localparam int HOLD_W = 4;
  localparam logic [CNT_W-1:0] LAST_SLOT = 3'd4;
`else
  localparam int CNT_W  = 2;
  localparam int HOLD_W = 3;
  localparam logic [CNT_W-1:0] LAST_SLOT = 2'd3;
`endif
  localparam logic [CNT_W-1:0] SLOT_ZERO = '0;
  localparam logic [CNT_W-1:0] SLOT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SLOT_TWO  = CNT_W'(2);
  localparam logic [3:0]       MISS_MAX  = 4'(SYNC_MISS_MAX);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   slot_q, slot_d;
  logic [2:0]         miss_q, miss_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [3:0]         data_q, data_d;   // {a,b,c,d}
  logic               fv_q, fv_d;
  logic               se_q, se_d;
  logic               pe_q, pe_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    hold_d  = hold_q;
    data_d  = data_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    pe_d    = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            hold_d[0] = din;
            slot_d    = SLOT_ONE;
            miss_d    = 3'd0;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (sync && slot_q != SLOT_ZERO) begin
            // Early sync: drop the partial frame and restart on this bit.
            se_d      = 1'b1;
            hold_d[0] = din;
            slot_d    = SLOT_ONE;
            miss_d    = 3'd0;
          end else if (slot_q == SLOT_ZERO) begin
            if (sync) begin
              hold_d[0] = din;
              slot_d    = SLOT_ONE;
              miss_d    = 3'd0;
            end else if (({1'b0, miss_q} + 4'd1) < MISS_MAX) begin
              hold_d[0] = din;
              slot_d    = SLOT_ONE;
              miss_d    = miss_q + 3'd1;
            end else begin
              state_d = HUNT;
              slot_d  = SLOT_ZERO;
              miss_d  = 3'd0;
            end
          end else if (slot_q == LAST_SLOT) begin
            slot_d = SLOT_ZERO;
`ifdef DEMUX_PARITY_EN
            if (din == ^hold_q) begin
              data_d = {hold_q[0], hold_q[1], hold_q[2], hold_q[3]};
              fv_d   = 1'b1;
            end else begin
              pe_d = 1'b1;
            end
`else
            data_d = {hold_q[0], hold_q[1], hold_q[2], din};
            fv_d   = 1'b1;
`endif
          end else begin
            if (slot_q == SLOT_ONE) begin
              hold_d[1] = din;
            end else if (slot_q == SLOT_TWO) begin
              hold_d[2] = din;
            end
`ifdef DEMUX_PARITY_EN
            else begin
              hold_d[3] = din;
            end
`endif
            slot_d = slot_q + SLOT_ONE;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      miss_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      pe_q    <= pe_d;
    end
  end

  assign a           = data_q[3];
  assign b           = data_q[2];
  assign c           = data_q[1];
  assign d           = data_q[0];
  assign frame_valid = fv_q;
  assign sync_err    = se_q;
  assign locked      = (state_q == LOCKED);
  assign s0          = slot_q[0];
  assign s1          = slot_q[1];
`ifdef DEMUX_PARITY_EN
  assign parity_err  = pe_q;
`else
  logic unused_pe;
  assign unused_pe   = pe_q;
`endif

endmodule

// File: tb/tb_one_bit_one_to_four_tdm_demux.sv
module tb_one_bit_one_to_four_tdm_demux;

  logic clk = 1'b0;
  logic reset_n, en, din, sync;
  logic a, b, c, d, frame_valid, locked, sync_err, s0, s1;
`ifdef DEMUX_PARITY_EN
  logic parity_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_data = 4'h0;

  always #5 clk = ~clk;

  one_bit_one_to_four_tdm_demux #(.SYNC_MISS_MAX(2)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .din(din), .sync(sync),
    .a(a), .b(b), .c(c), .d(d), .frame_valid(frame_valid),
    .locked(locked), .sync_err(sync_err), .s0(s0), .s1(s1)
`ifdef DEMUX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs checked #1 after the edge. A frame_valid pulse pops the scoreboard.
  task automatic observe(input string tag, input logic e_fv, input logic e_se,
                         input logic e_pe, input logic e_lk, input logic [1:0] e_slot);
    chk({tag, ".frame_valid"}, {3'b0, frame_valid}, {3'b0, e_fv});
    chk({tag, ".sync_err"}, {3'b0, sync_err}, {3'b0, e_se});
`ifdef DEMUX_PARITY_EN
    chk({tag, ".parity_err"}, {3'b0, parity_err}, {3'b0, e_pe});
`else
    if (e_pe) chk({tag, ".parity_err_unexpected"}, 4'h0, 4'h1);
`endif
    chk({tag, ".locked"}, {3'b0, locked}, {3'b0, e_lk});
    chk({tag, ".slot"}, {2'b0, s1, s0}, {2'b0, e_slot});
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) chk({tag, ".unexpected_frame"}, 4'h1, 4'h0);
      else exp_data = exp_q.pop_front();
    end
    chk({tag, ".abcd"}, {a, b, c, d}, exp_data);
  endtask

  task automatic step(input string tag, input logic i_en, input logic i_din, input logic i_sync,
                      input logic e_fv, input logic e_se, input logic e_pe,
                      input logic e_lk, input logic [1:0] e_slot);
    @(negedge clk);
    en = i_en; din = i_din; sync = i_sync;
    @(posedge clk);
    #1;
    observe(tag, e_fv, e_se, e_pe, e_lk, e_slot);
  endtask

  task automatic do_reset(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset_n = 1'b0; en = 1'b1; din = 1'b1; sync = 1'b1;
      @(posedge clk);
      #1;
    end
    exp_data = 4'h0;
    observe(tag, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    reset_n = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0;
    do_reset("reset", 2);

`ifdef DEMUX_PARITY_EN
    step("p0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("p1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("p2", 1, 0, 0, 0, 0, 0, 1, 2'd3);
    step("p3", 1, 0, 0, 0, 0, 0, 1, 2'd0);
    exp_q.push_back(4'b1100);
    step("p4", 1, 0, 0, 1, 0, 0, 1, 2'd0);
    step("q0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("q1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    step("q2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    step("q3", 1, 1, 0, 0, 0, 0, 1, 2'd0);
    step("q4_bad", 1, 0, 0, 0, 0, 1, 1, 2'd0);
    step("q_after", 1, 0, 1, 0, 0, 0, 1, 2'd1);
`else
    // Clean frame 1,0,1,1
    step("clean0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("clean1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    step("clean2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1011);
    step("clean3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    // Intermediate frame 0,1,1,0 so the stalled frame is a visible change
    step("mid0", 1, 0, 1, 0, 0, 0, 1, 2'd1);
    step("mid1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("mid2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b0110);
    step("mid3", 1, 0, 0, 1, 0, 0, 1, 2'd0);
    // Stall between slots 1 and 2; sync/din toggled while en=0 must be ignored
    step("stall0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("stall1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    for (int i = 0; i < 3; i++) step("stall_idle", 0, i[0], 1, 0, 0, 0, 1, 2'd2);
    step("stall2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1011);
    step("stall3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    // Early sync at slot 2: that bit starts frame 1,0,0,0
    step("early0", 1, 0, 1, 0, 0, 0, 1, 2'd1);
    step("early1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("early_sync", 1, 1, 1, 0, 1, 0, 1, 2'd1);
    step("early_n1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    step("early_n2", 1, 0, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1000);
    step("early_n3", 1, 0, 0, 1, 0, 0, 1, 2'd0);
    // Flywheel frame 0,1,0,1 with no sync
    step("fly0", 1, 0, 0, 0, 0, 0, 1, 2'd1);
    step("fly1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("fly2", 1, 0, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b0101);
    step("fly3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    // Second missing sync drops lock; bit discarded
    step("loss", 1, 1, 0, 0, 0, 0, 0, 2'd0);
    step("hunt_ignore", 1, 1, 0, 0, 0, 0, 0, 2'd0);
    // Relock with 1,1,1,1
    step("relock0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("relock1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("relock2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1111);
    step("relock3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    // Flywheel, then a sync clears the miss count, then flywheel again
    step("m0", 1, 0, 0, 0, 0, 0, 1, 2'd1);
    step("m1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    step("m2", 1, 1, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b0011);
    step("m3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    step("n0", 1, 1, 1, 0, 0, 0, 1, 2'd1);
    step("n1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    step("n2", 1, 0, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1100);
    step("n3", 1, 0, 0, 1, 0, 0, 1, 2'd0);
    step("o0", 1, 1, 0, 0, 0, 0, 1, 2'd1);
    step("o1", 1, 0, 0, 0, 0, 0, 1, 2'd2);
    step("o2", 1, 0, 0, 0, 0, 0, 1, 2'd3);
    exp_q.push_back(4'b1001);
    step("o3", 1, 1, 0, 1, 0, 0, 1, 2'd0);
    // Reset mid-frame at slot 2
    step("rm0", 1, 0, 1, 0, 0, 0, 1, 2'd1);
    step("rm1", 1, 1, 0, 0, 0, 0, 1, 2'd2);
    do_reset("reset_mid", 1);
    step("post_reset_hunt", 1, 1, 0, 0, 0, 0, 0, 2'd0);
`endif

    chk("scoreboard_empty", 4'(exp_q.size()), 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
